// File: rtl/display_7seg_scan.sv
// Scanned seven-segment driver with sequential double-dabble BCD conversion.
// Optional leading-zero blanking: define DISPLAY_7SEG_SCAN_LZB_EN.
module display_7seg_scan #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    bin,
    input  logic                load,
    input  logic                hex_mode,
    output logic                busy,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam int DW = 4 * N_DIGITS;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int KW = $clog2(BIN_W + 1);
    localparam logic [63:0]   DMAX = pow10(N_DIGITS) - 64'd1;
    localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(N_DIGITS - 1);
    localparam logic [KW-1:0] KMAX = KW'(BIN_W - 1);
    localparam logic [4:0]    DASH  = 5'd16;
    localparam logic [4:0]    BLANK = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t            state, state_n;
    logic              accept, step, commit;
    logic [BIN_W-1:0]  sh;
    logic [DW-1:0]     bcd, adj;
    logic              hexm, ovf, cap_ovf;
    logic [KW-1:0]     it;
    logic [63:0]       bin64;
    logic [4:0]        dig   [N_DIGITS];
    logic [4:0]        dig_n [N_DIGITS];
    logic [CW-1:0]     pre;
    logic [IW-1:0]     idx;

    function automatic logic [6:0] enc(input logic [4:0] c);
        case (c)
            5'd0:    enc = 7'b1000000;
            5'd1:    enc = 7'b1111001;
            5'd2:    enc = 7'b0100100;
            5'd3:    enc = 7'b0110000;
            5'd4:    enc = 7'b0011001;
            5'd5:    enc = 7'b0010010;
            5'd6:    enc = 7'b0000010;
            5'd7:    enc = 7'b1111000;
            5'd8:    enc = 7'b0000000;
            5'd9:    enc = 7'b0010000;
            5'd10:   enc = 7'b0001000;
            5'd11:   enc = 7'b0000011;
            5'd12:   enc = 7'b1000110;
            5'd13:   enc = 7'b0100001;
            5'd14:   enc = 7'b0000110;
            5'd15:   enc = 7'b0001110;
            DASH:    enc = 7'b0111111;
            default: enc = 7'b1111111;
        endcase
    endfunction

    assign bin64   = 64'(bin);
    assign cap_ovf = hex_mode ? ((bin64 >> DW) != 64'd0)
                              : (bin64 > DMAX);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    accept  = 1'b1;
                    state_n = hex_mode ? COMMIT : SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (it == KMAX) state_n = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < N_DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

`ifdef DISPLAY_7SEG_SCAN_LZB_EN
    logic lead;
`endif

    always_comb begin
`ifdef DISPLAY_7SEG_SCAN_LZB_EN
        lead = 1'b1;
`endif
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            dig_n[i] = {1'b0, bcd[4*i +: 4]};
            if (ovf) dig_n[i] = DASH;
`ifdef DISPLAY_7SEG_SCAN_LZB_EN
            // Blank while still inside the run of leading zeros.
            else if (!hexm && lead && i != 0 && bcd[4*i +: 4] == 4'd0)
                dig_n[i] = BLANK;
            if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            hexm <= 1'b0;
            ovf  <= 1'b0;
            it   <= '0;
            for (int i = 0; i < N_DIGITS; i++) dig[i] <= 5'd0;
        end else begin
            if (accept) begin
                hexm <= hex_mode;
                ovf  <= cap_ovf;
                it   <= '0;
                if (hex_mode) begin
                    bcd <= bin64[DW-1:0];
                end else begin
                    bcd <= '0;
                    sh  <= bin;
                end
            end
            if (step) begin
                bcd <= {adj[DW-2:0], sh[BIN_W-1]};
                sh  <= sh << 1;
                it  <= it + 1'b1;
            end
            if (commit)
                for (int i = 0; i < N_DIGITS; i++) dig[i] <= dig_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
            seg <= 7'b1111111;
            an  <= '1;
        end else begin
            if (pre == CMAX) begin
                pre <= '0;
                idx <= (idx == IMAX) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            seg <= enc(dig[idx]);
            an  <= ~(N_DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Randomized self-checking bench for display_7seg_scan.
// Expected digits come from plain decimal/hex arithmetic on the loaded value.
module tb_display_7seg_scan;

    localparam int N = 4;
    localparam int W = 14;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         hex_mode = 1'b0;
    logic [W-1:0] bin = '0;
    logic         busy;
    logic [6:0]   seg;
    logic [N-1:0] an;

    int n_vec  = 0;
    int n_fail = 0;
    logic [6:0] exp_d [N];

    display_7seg_scan #(
        .N_DIGITS(N),
        .BIN_W(W),
        .SCAN_DIV(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bin(bin),
        .load(load),
        .hex_mode(hex_mode),
        .busy(busy),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segcode(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            16: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model(input int v, input bit hx);
        int p;
        if (hx) begin
            for (int i = 0; i < N; i++)
                exp_d[i] = segcode((v >> (4 * i)) & 15);
        end else if (v > 9999) begin
            for (int i = 0; i < N; i++) exp_d[i] = segcode(16);
        end else begin
            p = 1;
            for (int i = 0; i < N; i++) begin
                exp_d[i] = segcode((v / p) % 10);
`ifdef DISPLAY_7SEG_SCAN_LZB_EN
                if (i > 0 && v < p) exp_d[i] = segcode(17);
`endif
                p = p * 10;
            end
        end
    endtask

    task automatic check_display(input string name);
        int zeros;
        int idx;
        logic [N-1:0] seen;
        seen = '0;
        repeat (20) begin
            @(negedge clk);
            zeros = 0;
            idx = 0;
            for (int i = 0; i < N; i++)
                if (an[i] === 1'b0) begin
                    zeros++;
                    idx = i;
                end
            n_vec++;
            if (zeros !== 1) begin
                n_fail++;
                $display("FAIL %s an_onehot: an=%b", name, an);
            end else begin
                n_vec++;
                if (seg !== exp_d[idx]) begin
                    n_fail++;
                    $display("FAIL %s digit%0d: seg=%b want=%b",
                             name, idx, seg, exp_d[idx]);
                end
                seen[idx] = 1'b1;
            end
        end
        n_vec++;
        if (seen !== '1) begin
            n_fail++;
            $display("FAIL %s scan_cover: seen=%b want=1111", name, seen);
        end
    endtask

    task automatic do_load(input int v, input bit hx,
                           input int exp_busy, input string name);
        int n;
        bin = W'(v);
        hex_mode = hx;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_vec++;
        if (n !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_len: got=%0d want=%0d",
                     name, n, exp_busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 3;
        if (seg !== 7'b1111111) begin
            n_fail++;
            $display("FAIL rst_seg: seg=%b want=1111111", seg);
        end
        if (an !== 4'b1111) begin
            n_fail++;
            $display("FAIL rst_an: an=%b want=1111", an);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: busy=%b want=0", busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec += 2;
        if (an !== 4'b1110) begin
            n_fail++;
            $display("FAIL rel_an: an=%b want=1110", an);
        end
        if (seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rel_seg: seg=%b want=1000000", seg);
        end
    endtask

    task automatic test_decimal;
        int vals [5] = '{1234, 9999, 42, 0, 7};
        foreach (vals[k]) begin
            model(vals[k], 1'b0);
            do_load(vals[k], 1'b0, W + 1, "dec");
            check_display("dec");
        end
    endtask

    task automatic test_overflow;
        model(10000, 1'b0);
        do_load(10000, 1'b0, W + 1, "ovf_dec");
        check_display("ovf_dec");
        model(16383, 1'b0);
        do_load(16383, 1'b0, W + 1, "ovf_max");
        check_display("ovf_max");
        model(16'h1A3F, 1'b1);
        do_load(16'h1A3F, 1'b1, 1, "hex");
        check_display("hex");
        model(16383, 1'b1);
        do_load(16383, 1'b1, 1, "hex_max");
        check_display("hex_max");
    endtask

    task automatic test_handshake;
        int n;
        bin = '0;
        hex_mode = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            bin = W'(9999);
            load = (n == 4);
            @(negedge clk);
        end
        load = 1'b0;
        n_vec++;
        if (n !== W + 1) begin
            n_fail++;
            $display("FAIL hs_busy_len: got=%0d want=%0d", n, W + 1);
        end
        model(0, 1'b0);
        check_display("hs_drop");
    endtask

    task automatic test_back_to_back;
        do_load(4321, 1'b0, W + 1, "b2b_a");
        model(16'h2C5D, 1'b1);
        do_load(16'h2C5D, 1'b1, 1, "b2b_b");
        check_display("b2b");
    endtask

    task automatic test_random;
        int v;
        bit hx;
        repeat (10) begin
            v = int'($urandom_range(0, 16383));
            hx = 1'($urandom_range(0, 1));
            model(v, hx);
            do_load(v, hx, hx ? 1 : W + 1, "rand");
            check_display("rand");
        end
    endtask

    task automatic test_abort;
        model(8765, 1'b0);
        do_load(8765, 1'b0, W + 1, "abort_pre");
        check_display("abort_pre");
        bin = W'(1234);
        hex_mode = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec += 3;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: busy=%b want=0", busy);
        end
        if (seg !== 7'b1111111) begin
            n_fail++;
            $display("FAIL abort_seg: seg=%b want=1111111", seg);
        end
        if (an !== 4'b1111) begin
            n_fail++;
            $display("FAIL abort_an: an=%b want=1111", an);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) exp_d[i] = segcode(0);
        check_display("abort_clear");
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_overflow();
        test_handshake();
        test_back_to_back();
        test_random();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/display_7seg_scan.md
# display_7seg_scan

Multi-digit, time-multiplexed seven-segment driver for the lab boards. It accepts a binary value and converts it to N_DIGITS of BCD with a sequential double-dabble engine, or shows it as hexadecimal digits. It then scans the digits onto one shared active-low segment bus with per-digit active-low anode enables. It replaces per-digit combinational decoders wherever a board exposes a common segment bus.

## Interface
- N_DIGITS, 4: number of digits scanned; range 1..8.
- BIN_W, 14: width of `bin`; range 1..32.
- SCAN_DIV, 50000: clock cycles each digit stays enabled; must be ≥ 1.
- clk  in  1: sole clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- bin  in  BIN_W: value to display, sampled on accepted `load`.
- load  in  1: single-cycle request to capture `bin` and `hex_mode`.
- hex_mode  in  1: 1 selects hex display; 0 selects decimal.
- busy  out  1: conversion in progress; `load` is ignored while high.
- seg  out  7: active-low segments, bit order gfedcba.
- an  out  N_DIGITS: active-low digit enables; bit i is digit i, and digit 0 is least significant.

## Operation
- Encodings (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - dash=0111111, blank=1111111
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: `load`=1 captures `bin` and `hex_mode`.
    - Decimal → SHIFT.
    - Hex → COMMIT.
  - SHIFT: runs exactly BIN_W double-dabble iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit. Then → COMMIT.
  - COMMIT: writes the digit register, then → IDLE.
- Overflow is evaluated at capture time and forces all digits to dash at COMMIT.
  - Decimal: overflow when the captured value > 10^N_DIGITS − 1.
  - Hex: overflow when any captured bit at index ≥ 4·N_DIGITS is 1.
- Hex mode: digit i = captured bits [4i+3:4i], zero-extended when BIN_W < 4·N_DIGITS.
- The digit register holds N_DIGITS codes of 5 bits (value 0..15, dash, blank). It is separate from the working registers, so the display stays stable during a conversion.
- Scanner:
  - A prescaler counts 0..SCAN_DIV−1.
  - On wrap, the digit index advances i → i+1, and N_DIGITS−1 → 0.
  - `an` has exactly one low bit, at the index; `seg` is the encoding of digit register[index].
- The scanner runs independently of the FSM and never pauses.

## Timing
- Reset values:
  - `seg`=1111111, `an` all 1s, `busy`=0.
  - FSM=IDLE; prescaler and index = 0; digit register all value 0.
- First cycle after `rst` deasserts: registered outputs show digit 0 (`an`[0]=0, `seg`=1000000).
- `seg` and `an` are registered: one cycle from index or digit-register change to output.
- `busy` rises the cycle after an accepted `load` and stays high through COMMIT.
  - Decimal: `busy` high BIN_W+1 cycles.
  - Hex: `busy` high 1 cycle.
- The digit register updates at the end of the COMMIT cycle. A new value reaches `seg` on the next cycle, if its digit is selected.
- `load` while `busy`=1 is dropped with no side effect. `load` on the cycle `busy` falls is accepted.
- `rst` mid-conversion aborts immediately and restores all reset values, including a cleared digit register.
- SCAN_DIV=1: the index advances every cycle.

## Configuration
- Macro: `DISPLAY_7SEG_SCAN_LZB_EN`.
- Defined: at COMMIT, in decimal mode without overflow, leading zero digits from the top down are replaced by blank. Digit 0 is never blanked. Hex and dash results are unaffected.
- Undefined: leading zeros are shown as 0, and no blanking logic is built.

## Test plan
Bench parameters for all scenarios: N_DIGITS=4, BIN_W=14, SCAN_DIV=4.
- Reset: hold `rst` 3 cycles → `seg`=1111111, `an`=1111, `busy`=0. Then release → `an`=1110, `seg`=1000000.
- Decimal: `load` `bin`=1234 → `busy` high 15 cycles. Then digit0=0011001 (4) at `an`=1110, digit1=0110000 (3), digit2=0100100 (2), digit3=1111001 (1) at `an`=0111.
- Overflow: `bin`=10000 decimal → every digit shows 0111111. Hex `bin`=0x1A3F → digits F, 3, A, 1 (0001110, 0110000, 0001000, 1111001); `busy` high 1 cycle.
- Handshake: `load` 9999 while busy with 0 → the second request is ignored and the display shows 0000. Assert `rst` at SHIFT cycle 7 → next cycle `busy`=0 and all digits show 0.
- Blanking, macro defined: `bin`=42 → digits 3 and 2 show 1111111 while `an` keeps scanning; digit1=0011001, digit0=0100100. `bin`=0 → digit0=1000000. Macro undefined: `bin`=42 → digits 3 and 2 show 1000000.
